// File: rtl/logicnets_pkg.sv
// Layer width constants shared by the LogicNets layer wrappers and the inter-layer pipes.
package logicnets_pkg;
  localparam int L0_OUT_W = 16;
  localparam int L1_IN_W  = 16;

  typedef logic [1:0] pipe_occ_t;
endpackage

// File: rtl/logicnets_layer_pipe.sv
// Registered valid/ready stage with a 2-entry skid buffer between two combinational LUT layers.
// Every output comes straight from a flop, so back-pressure never creates a combinational ready path.
module logicnets_layer_pipe
  import logicnets_pkg::L0_OUT_W;
#(
  parameter int DATA_W = L0_OUT_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  vec_cnt
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              emit;

  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign occupancy = skid_valid ? 2'd2 : {1'b0, out_valid};

  // Main entry, skid flag, ready and counter; main data sits here because reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
      vec_cnt    <= '0;
    end else begin
      // Downstream consumed the vector even if a flush discards the rest
      if (emit) vec_cnt <= vec_cnt + CNT_W'(1);

      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (skid_valid) begin
        if (out_ready) begin
          out_data   <= skid_data;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end
      end else if (out_valid) begin
        in_ready <= 1'b1;
        if (accept && !out_ready) begin
          skid_valid <= 1'b1;
          in_ready   <= 1'b0;
        end else if (accept) begin
          out_data <= in_data;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end else begin
        in_ready <= 1'b1;
        if (accept) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end
      end
    end
  end

  // Skid payload is qualified by skid_valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (accept && out_valid && !skid_valid && !out_ready && !flush) skid_data <= in_data;
  end

endmodule

// File: tb/tb_logicnets_layer_pipe.sv
// Directed and randomized checks of the LogicNets inter-layer skid pipe.
// A second instance with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_logicnets_layer_pipe;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic              in_ready,  in_ready_w;
  logic              out_valid, out_valid_w;
  logic [DATA_W-1:0] out_data,  out_data_w;
  logic [1:0]        occupancy, occupancy_w;
  logic [15:0]       vec_cnt;
  logic [3:0]        vec_cnt_w;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  logicnets_layer_pipe #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .vec_cnt(vec_cnt)
  );

  logicnets_layer_pipe #(.DATA_W(DATA_W), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w),
    .out_valid(out_valid_w), .out_data(out_data_w), .out_ready(out_ready),
    .occupancy(occupancy_w), .vec_cnt(vec_cnt_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) cyc();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    rst_n = 1'b1;
    cyc();
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);
  endtask

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_v;
  int accepted, emitted, cycles;

  initial begin
    do_reset();

    // Streaming 0x0001..0x0010 at full rate
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = DATA_W'(i);
      cyc();
      check("stream_data", 32'(out_data), 32'(i));
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_occ", 32'(occupancy), 32'd1);
    end
    check("stream_cnt15", 32'(vec_cnt), 32'd15);
    in_valid = 1'b0;
    cyc();
    check("stream_cnt16", 32'(vec_cnt), 32'd16);
    check("stream_empty_valid", 32'(out_valid), 32'd0);
    check("stream_hold_data", 32'(out_data), 32'h0010);
    check("stream_empty_occ", 32'(occupancy), 32'd0);

    // Back-pressure fills both entries
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hA5A5;
    cyc();
    check("bp_occ1", 32'(occupancy), 32'd1);
    in_data = 16'h5A5A;
    cyc();
    check("bp_occ2", 32'(occupancy), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_data", 32'(out_data), 32'hA5A5);
    in_valid = 1'b0; in_data = 16'hFFFF;
    cyc();
    check("bp_data_stable", 32'(out_data), 32'hA5A5);
    check("bp_occ2_stable", 32'(occupancy), 32'd2);
    out_ready = 1'b1;
    cyc();
    check("bp_second", 32'(out_data), 32'h5A5A);
    check("bp_second_occ", 32'(occupancy), 32'd1);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_cnt17", 32'(vec_cnt), 32'd17);
    cyc();
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_cnt18", 32'(vec_cnt), 32'd18);

    // Flush at occupancy 2 with in_valid high
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1111;
    cyc();
    in_data = 16'h2222;
    cyc();
    check("fl_pre_occ", 32'(occupancy), 32'd2);
    flush = 1'b1; in_data = 16'h9999;
    cyc();
    check("fl_occ", 32'(occupancy), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_cnt_kept", 32'(vec_cnt), 32'd18);
    flush = 1'b0; in_data = 16'h1234;
    cyc();
    check("fl_first_valid", 32'(out_valid), 32'd1);
    check("fl_first_data", 32'(out_data), 32'h1234);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    check("fl_first_cnt", 32'(vec_cnt), 32'd19);
    // Flush during an emit still counts the emitted vector
    in_valid = 1'b1; in_data = 16'h7777; out_ready = 1'b0;
    cyc();
    flush = 1'b1; out_ready = 1'b1; in_data = 16'h8888;
    cyc();
    check("fl_emit_cnt", 32'(vec_cnt), 32'd20);
    check("fl_emit_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;

    // Random traffic against a FIFO scoreboard
    do_reset();
    q.delete(); accepted = 0; emitted = 0; cycles = 0;
    while (accepted < 10000 && cycles < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DATA_W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rnd_spurious", 32'(out_data), 32'hDEAD_0000);
        else begin
          exp_v = q.pop_front();
          check("rnd_order", 32'(out_data), 32'(exp_v));
        end
        emitted++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        accepted++;
      end
      cyc();
      cycles++;
    end
    check("rnd_accept_budget", 32'(accepted), 32'd10000);
    in_valid = 1'b0; out_ready = 1'b1; cycles = 0;
    while (out_valid && cycles < 10) begin
      if (q.size() == 0) check("rnd_spurious", 32'(out_data), 32'hDEAD_0000);
      else begin
        exp_v = q.pop_front();
        check("rnd_order", 32'(out_data), 32'(exp_v));
      end
      emitted++;
      cyc();
      cycles++;
    end
    check("rnd_leftover", 32'(q.size()), 32'd0);
    check("rnd_emitted", 32'(emitted), 32'd10000);
    check("rnd_vec_cnt", 32'(vec_cnt), 32'(emitted % 65536));
    check("rnd_vec_cnt_w", 32'(vec_cnt_w), 32'(emitted % 16));

    // Counter wrap on the 4-bit instance
    do_reset();
    check("wrap_rst", 32'(vec_cnt_w), 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = DATA_W'(16'h0100 + i);
      cyc();
    end
    check("wrap_15", 32'(vec_cnt_w), 32'd15);
    in_data = 16'h0111;
    cyc();
    check("wrap_0", 32'(vec_cnt_w), 32'd0);
    check("wrap_wide16", 32'(vec_cnt), 32'd16);
    in_valid = 1'b0;
    cyc();
    check("wrap_1", 32'(vec_cnt_w), 32'd1);
    check("wrap_last_data", 32'(out_data_w), 32'h0111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
